sci_alu_arbiter: RTL and testbench

- Shares one latched scientific_alu instance between two requesters.
- Each requester presents a, b (IEEE-754 double bit vectors) and a 4-bit opcode on a valid/ready request channel.
- The block arbitrates round-robin, drives the ALU enable for a fixed evaluation window, and captures result/excep/err. It then returns them on the winning requester's valid/ready response channel.
- It sits between the bus-side command agents and the ALU shell, and is the only driver of the ALU's enable, a_in, b_in and opcode.

---
 rtl/sci_alu_pkg.sv | 18 +
 rtl/sci_alu_arbiter_if.sv | 28 ++
 rtl/sci_alu_rr_grant.sv | 18 +
 rtl/sci_alu_arbiter.sv | 120 ++++++++++++
 tb/tb_sci_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sci_alu_pkg.sv
// Shared types and constants for the scientific ALU arbiter and its benches.
package sci_alu_pkg;

   localparam int unsigned DataWidth = 64;
   localparam int unsigned OpWidth   = 4;

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

   // IEEE-754 double bit patterns for commonly used operands.
   localparam logic [DataWidth-1:0] DblZero      = 64'h0000_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblTwo       = 64'h4000_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblEight     = 64'h4020_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblFourteen  = 64'h402C_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblSixteen   = 64'h4030_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblEighteen  = 64'h4032_0000_0000_0000;
   localparam logic [DataWidth-1:0] DblThirtyTwo = 64'h4040_0000_0000_0000;

endpackage

// File: rtl/sci_alu_arbiter_if.sv
// Request/response channels between the command agents and the ALU arbiter.
interface sci_alu_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   import sci_alu_pkg::*;

   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0]                req_ready;
   logic [NREQ-1:0][DataWidth-1:0] req_a;
   logic [NREQ-1:0][DataWidth-1:0] req_b;
   logic [NREQ-1:0][OpWidth-1:0]   req_op;
   logic [NREQ-1:0]                resp_valid;
   logic [NREQ-1:0]                resp_ready;
   logic [DataWidth-1:0]           resp_result;
   logic                           resp_excep;
   logic                           resp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_excep, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_result, resp_excep, resp_err
   );

endinterface

// File: rtl/sci_alu_rr_grant.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
module sci_alu_rr_grant (
   input  logic [1:0] req_valid,
   input  logic       rr_ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/sci_alu_arbiter.sv
// Shares one latched scientific ALU between two requesters: round-robin grant,
// fixed-length enable window, captured result returned to the winning requester.
module sci_alu_arbiter
   import sci_alu_pkg::*;
#(
   parameter int unsigned ALU_LAT = 2,
   parameter int unsigned NREQ    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sci_alu_arbiter_if.slave     bus,
   output logic                 alu_enable,
   output logic [DataWidth-1:0] alu_a,
   output logic [DataWidth-1:0] alu_b,
   output logic [OpWidth-1:0]   alu_op,
   input  logic [DataWidth-1:0] alu_result,
   input  logic                 alu_excep,
   input  logic                 alu_err,
   output logic                 busy
);

   localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

   state_e               state_q, state_d;
   logic                 rr_ptr_q, rr_ptr_d;
   logic                 owner_q, owner_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DataWidth-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [OpWidth-1:0]   op_q, op_d;
   logic                 excep_q, excep_d, err_q, err_d;
   logic [NREQ-1:0]      grant;

   sci_alu_rr_grant u_grant (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant)
   );

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      cnt_d          = cnt_q;
      a_d            = a_q;
      b_d            = b_q;
      op_d           = op_q;
      res_d          = res_q;
      excep_d        = excep_q;
      err_d          = err_q;
      bus.req_ready  = 2'b00;
      bus.resp_valid = 2'b00;
      alu_enable     = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.req_ready = grant;
            if ((bus.req_valid & grant) != 2'b00) begin
               owner_d  = grant[1];
               rr_ptr_d = ~grant[1];
               a_d      = bus.req_a[grant[1]];
               b_d      = bus.req_b[grant[1]];
               op_d     = bus.req_op[grant[1]];
               cnt_d    = CntInit;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            alu_enable = 1'b1;
            if (cnt_q == 4'd0) begin
               res_d   = alu_result;
               excep_d = alu_excep;
               err_d   = alu_err;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            bus.resp_valid = owner_q ? 2'b10 : 2'b01;
            // Only the owner's ready retires the response.
            if (bus.resp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= 1'b0;
         owner_q  <= 1'b0;
         cnt_q    <= 4'd0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         res_q    <= '0;
         excep_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         res_q    <= res_d;
         excep_q  <= excep_d;
         err_q    <= err_d;
      end
   end

   assign alu_a           = a_q;
   assign alu_b           = b_q;
   assign alu_op          = op_q;
   assign bus.resp_result = res_q;
   assign bus.resp_excep  = excep_q;
   assign bus.resp_err    = err_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_sci_alu_arbiter.sv
// Scoreboard bench for sci_alu_arbiter with a behavioural latched ALU.
module tb_sci_alu_arbiter;
   import sci_alu_pkg::*;

   typedef struct {
      logic [1:0]  own;
      logic [63:0] res;
      logic        ex;
      logic        er;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;
   exp_t exp_q[$];
   exp_t mon_e;

   sci_alu_arbiter_if #(.NREQ(2)) bus ();
   sci_alu_arbiter_if #(.NREQ(2)) bus1 ();
   sci_alu_arbiter_if #(.NREQ(2)) bus15 ();

   logic        alu_enable, alu_excep, alu_err, busy;
   logic [63:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;

   logic        en1, en15, busy1, busy15;
   logic [63:0] a1, b1, a15, b15;
   logic [3:0]  op1, op15;

   sci_alu_arbiter #(.ALU_LAT(2), .NREQ(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .alu_enable(alu_enable), .alu_a(alu_a),
      .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_excep(alu_excep),
      .alu_err(alu_err), .busy(busy)
   );

   sci_alu_arbiter #(.ALU_LAT(1), .NREQ(2)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .alu_enable(en1), .alu_a(a1), .alu_b(b1),
      .alu_op(op1), .alu_result(DblEighteen), .alu_excep(1'b0), .alu_err(1'b0),
      .busy(busy1)
   );

   sci_alu_arbiter #(.ALU_LAT(15), .NREQ(2)) u_lat15 (
      .clk(clk), .rst_n(rst_n), .bus(bus15), .alu_enable(en15), .alu_a(a15), .alu_b(b15),
      .alu_op(op15), .alu_result(DblEighteen), .alu_excep(1'b0), .alu_err(1'b0),
      .busy(busy15)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: {excep, err, result}; transparent while enabled, frozen otherwise.
   function automatic logic [65:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] op);
      real         ra, rb;
      logic [63:0] r;
      logic        ex, er;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      r  = 64'd0;
      ex = 1'b0;
      er = 1'b0;
      case (op)
         4'h0: r = $realtobits(ra + rb);
         4'h1: r = $realtobits(ra - rb);
         4'h2: r = $realtobits(ra * rb);
         4'h3: if (b[62:0] == 63'd0) er = 1'b1; else r = $realtobits(ra / rb);
         4'hF: begin r = a; ex = 1'b1; end
         default: er = 1'b1;
      endcase
      return {ex, er, r};
   endfunction

   always_latch begin
      if (alu_enable) {alu_excep, alu_err, alu_result} <= alu_f(alu_a, alu_b, alu_op);
   end

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endfunction

   // Monitor: pops one expectation per accepted response.
   always @(negedge clk) begin
      if (rst_n && (bus.resp_valid & bus.resp_ready) != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_owner", 64'(bus.resp_valid), 64'(mon_e.own));
            chk("resp_result", bus.resp_result, mon_e.res);
            chk("resp_excep", 64'(bus.resp_excep), 64'(mon_e.ex));
            chk("resp_err", 64'(bus.resp_err), 64'(mon_e.er));
         end
      end
   end

   task automatic push(input logic [1:0] own, input logic [63:0] res, input logic ex,
                       input logic er);
      exp_t e;
      e.own = own; e.res = res; e.ex = ex; e.er = er;
      exp_q.push_back(e);
   endtask

   task automatic wait_hs(input int r);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (bus.req_valid[r] && bus.req_ready[r]) seen = 1'b1;
      end
      chk("handshake_seen", 64'(seen), 64'd1);
      if (seen) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input int r, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op);
      bus.req_a[r]     = a;
      bus.req_b[r]     = b;
      bus.req_op[r]    = op;
      bus.req_valid[r] = 1'b1;
      wait_hs(r);
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int en_cnt, lat, hs;
      total = 0;
      passed = 0;
      rst_n = 1'b0;
      bus.req_valid = 2'b00;  bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      bus.resp_ready = 2'b11;
      bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0;
      bus1.resp_ready = 2'b11;
      bus15.req_valid = 2'b00; bus15.req_a = '0; bus15.req_b = '0; bus15.req_op = '0;
      bus15.resp_ready = 2'b11;

      // Reset state
      #3;
      chk("rst_enable", 64'(alu_enable), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_result", bus.resp_result, 64'd0);
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single op: 16.0 + 2.0, enable width 2, response 3 cycles after handshake
      push(2'b01, DblEighteen, 1'b0, 1'b0);
      issue(0, DblSixteen, DblTwo, 4'h0);
      en_cnt = 0;
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (alu_enable) en_cnt++;
         if (lat == 0 && bus.resp_valid != 2'b00) lat = c;
      end
      chk("single_enable_width", 64'(en_cnt), 64'd2);
      chk("single_resp_latency", 64'(lat), 64'd3);
      drain();

      // Reset one cycle after a req0 handshake (rr_ptr had moved to 1)
      issue(0, DblSixteen, DblTwo, 4'h2);
      @(posedge clk);
      #2;
      chk("pre_reset_enable", 64'(alu_enable), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_enable", 64'(alu_enable), 64'd0);
      chk("mid_reset_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("mid_reset_busy", 64'(busy), 64'd0);
      #13 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_reset_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Simultaneous requests: rr_ptr back to 0, so order is 0,1,0,1,...
      for (int i = 0; i < 4; i++) begin
         push(2'b01, DblEighteen, 1'b0, 1'b0);
         push(2'b10, DblThirtyTwo, 1'b0, 1'b0);
      end
      bus.req_a[0] = DblSixteen; bus.req_b[0] = DblTwo; bus.req_op[0] = 4'h0;
      bus.req_a[1] = DblSixteen; bus.req_b[1] = DblTwo; bus.req_op[1] = 4'h2;
      bus.req_valid = 2'b11;
      #1;
      chk("sim_first_grant", 64'(bus.req_ready), 64'd1);
      hs = 0;
      for (int c = 0; c < 200 && hs < 8; c++) begin
         @(negedge clk);
         if ((bus.req_valid & bus.req_ready) != 2'b00) hs++;
      end
      chk("sim_handshakes", 64'(hs), 64'd8);
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      drain();

      // Response stall: owner 0 withholds ready, req1 waits, non-owner ready ignored
      bus.resp_ready = 2'b10;
      push(2'b01, DblFourteen, 1'b0, 1'b0);
      issue(0, DblSixteen, DblTwo, 4'h1);
      push(2'b10, DblThirtyTwo, 1'b0, 1'b0);
      bus.req_a[1] = DblSixteen; bus.req_b[1] = DblTwo; bus.req_op[1] = 4'h2;
      bus.req_valid[1] = 1'b1;
      for (int c = 0; c < 20 && bus.resp_valid == 2'b00; c++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         chk("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
         chk("stall_result", bus.resp_result, DblFourteen);
         chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.resp_ready = 2'b11;
      wait_hs(1);
      bus.req_valid[1] = 1'b0;
      drain();

      // Error forwarding, recovery, and excep forwarding
      push(2'b01, DblZero, 1'b0, 1'b1);
      issue(0, DblSixteen, DblZero, 4'h3);
      push(2'b01, DblEight, 1'b0, 1'b0);
      issue(0, DblSixteen, DblTwo, 4'h3);
      push(2'b10, DblSixteen, 1'b1, 1'b0);
      issue(1, DblSixteen, DblTwo, 4'hF);
      drain();

      // Latency sweep: ALU_LAT=1 and ALU_LAT=15 instances handshake at the same edge
      bus1.req_valid = 2'b01;
      bus15.req_valid = 2'b01;
      @(posedge clk);
      #1;
      bus1.req_valid = 2'b00;
      bus15.req_valid = 2'b00;
      begin
         int e1, e15, l1, l15;
         e1 = 0; e15 = 0; l1 = 0; l15 = 0;
         for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (en1) e1++;
            if (en15) e15++;
            if (l1 == 0 && bus1.resp_valid != 2'b00) l1 = c;
            if (l15 == 0 && bus15.resp_valid != 2'b00) l15 = c;
         end
         chk("lat1_enable_width", 64'(e1), 64'd1);
         chk("lat1_resp_latency", 64'(l1), 64'd2);
         chk("lat15_enable_width", 64'(e15), 64'd15);
         chk("lat15_resp_latency", 64'(l15), 64'd16);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
